// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage: turns one fetched instruction per handshake into
// the ALU control word, operand selects, immediate and register indices for execute.
module alu_decode_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [3:0]      alu_control_o,
   output logic            op_a_sel_o,
   output logic            op_b_sel_o,
   output logic [XLEN-1:0] imm_o,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   output logic [4:0]      rd_addr_o,
   output logic            reg_write_o,
   output logic [XLEN-1:0] pc_out_o,
   output logic            illegal_o
);

   typedef enum logic [3:0] {
      ALU_ADD    = 4'h0,
      ALU_SUB    = 4'h1,
      ALU_SLL    = 4'h2,
      ALU_SLT    = 4'h3,
      ALU_SLTU   = 4'h4,
      ALU_XOR    = 4'h5,
      ALU_SRL    = 4'h6,
      ALU_SRA    = 4'h7,
      ALU_OR     = 4'h8,
      ALU_AND    = 4'h9,
      ALU_COPY_B = 4'hA
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic signed [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
   logic [31:0]        shamt;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   assign imm_i_s = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                     instr_i[11:8], 1'b0};
   assign imm_u_s = {instr_i[31:12], 12'b0};
   assign imm_j_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
   assign shamt   = {27'b0, instr_i[24:20]};

   alu_op_e     alu_d;
   logic        a_sel_d, b_sel_d, illegal_d, we_d, writes_rd;
   logic [31:0] imm_d;

   always_comb begin
      alu_d     = ALU_ADD;
      a_sel_d   = 1'b0;
      b_sel_d   = 1'b0;
      imm_d     = '0;
      writes_rd = 1'b0;
      illegal_d = 1'b0;
      case (opcode)
         OPC_OP: begin
            writes_rd = 1'b1;
            if (funct7 == F7_BASE) begin
               alu_d = f3_to_alu(funct3);
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               alu_d = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               alu_d = ALU_SRA;
            end else begin
               illegal_d = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            writes_rd = 1'b1;
            b_sel_d   = 1'b1;
            alu_d     = f3_to_alu(funct3);
            imm_d     = imm_i_s;
            // shift-immediates carry funct7 in the upper immediate bits
            if (funct3 == 3'b001) begin
               imm_d     = shamt;
               illegal_d = (funct7 != F7_BASE);
            end else if (funct3 == 3'b101) begin
               imm_d = shamt;
               if (funct7 == F7_ALT) begin
                  alu_d = ALU_SRA;
               end else if (funct7 != F7_BASE) begin
                  illegal_d = 1'b1;
               end
            end
         end
         OPC_LUI: begin
            writes_rd = 1'b1;
            alu_d     = ALU_COPY_B;
            b_sel_d   = 1'b1;
            imm_d     = imm_u_s;
         end
         OPC_AUIPC: begin
            writes_rd = 1'b1;
            a_sel_d   = 1'b1;
            b_sel_d   = 1'b1;
            imm_d     = imm_u_s;
         end
         OPC_LOAD: begin
            writes_rd = 1'b1;
            b_sel_d   = 1'b1;
            imm_d     = imm_i_s;
         end
         OPC_STORE: begin
            b_sel_d = 1'b1;
            imm_d   = imm_s_s;
         end
         OPC_BRANCH: begin
            imm_d = imm_b_s;
            case (funct3[2:1])
               2'b00:   alu_d = ALU_SUB;
               2'b10:   alu_d = ALU_SLT;
               2'b11:   alu_d = ALU_SLTU;
               default: illegal_d = 1'b1;
            endcase
         end
         OPC_JAL: begin
            writes_rd = 1'b1;
            a_sel_d   = 1'b1;
            b_sel_d   = 1'b1;
            imm_d     = imm_j_s;
         end
         OPC_JALR: begin
            writes_rd = 1'b1;
            b_sel_d   = 1'b1;
            imm_d     = imm_i_s;
            illegal_d = (funct3 != 3'b000);
         end
         default: illegal_d = 1'b1;
      endcase
      // an illegal bundle is presented as a harmless ADD with no side effects
      if (illegal_d) begin
         alu_d     = ALU_ADD;
         a_sel_d   = 1'b0;
         b_sel_d   = 1'b0;
         imm_d     = '0;
         writes_rd = 1'b0;
      end
      we_d = writes_rd & (instr_i[11:7] != 5'd0);
   end

   logic            valid_q, valid_d, capture;
   alu_op_e         alu_q;
   logic            a_sel_q, b_sel_q, we_q, illegal_q;
   logic [XLEN-1:0] imm_q, pc_q;
   logic [4:0]      rs1_q, rs2_q, rd_q;

   assign in_ready_o = ~valid_q | out_ready_i;
   assign capture    = in_valid_i & in_ready_o & ~flush_i;

   always_comb begin
      valid_d = valid_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d = 1'b1;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Decode -> execute pipeline register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q   <= 1'b0;
         alu_q     <= ALU_ADD;
         a_sel_q   <= 1'b0;
         b_sel_q   <= 1'b0;
         imm_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         we_q      <= 1'b0;
         pc_q      <= RESET_PC;
         illegal_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (capture) begin
            alu_q     <= alu_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            imm_q     <= imm_d;
            rs1_q     <= instr_i[19:15];
            rs2_q     <= instr_i[24:20];
            rd_q      <= instr_i[11:7];
            we_q      <= we_d;
            pc_q      <= pc_i;
            illegal_q <= illegal_d;
         end
      end
   end

   assign out_valid_o   = valid_q;
   assign alu_control_o = alu_q;
   assign op_a_sel_o    = a_sel_q;
   assign op_b_sel_o    = b_sel_q;
   assign imm_o         = imm_q;
   assign rs1_addr_o    = rs1_q;
   assign rs2_addr_o    = rs2_q;
   assign rd_addr_o     = rd_q;
   assign reg_write_o   = we_q;
   assign pc_out_o      = pc_q;
   assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: decode vector table, handshake corner sequences and a
// randomized run scored against an instruction-level reference model.
module tb_alu_decode_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] instr, pc, imm, pc_out;
   logic [3:0]  alu_control;
   logic        op_a_sel, op_b_sel, reg_write, illegal;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   alu_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instr_i(instr), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .alu_control_o(alu_control), .op_a_sel_o(op_a_sel),
      .op_b_sel_o(op_b_sel), .imm_o(imm), .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
      .rd_addr_o(rd_addr), .reg_write_o(reg_write), .pc_out_o(pc_out), .illegal_o(illegal)
   );

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  alu;
      logic        a;
      logic        b;
      logic [31:0] imm;
      logic        we;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic [31:0] ins, input logic [3:0] alu, input logic a,
                          input logic b, input logic [31:0] im, input logic we, input logic ill);
      vec_t v;
      v.instr = ins; v.alu = alu; v.a = a; v.b = b; v.imm = im; v.we = we; v.ill = ill;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic check_bundle(input string tag, input vec_t v, input logic [31:0] p);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'h1);
      chk({tag, ".alu"}, 32'(alu_control), 32'(v.alu));
      chk({tag, ".a_sel"}, 32'(op_a_sel), 32'(v.a));
      chk({tag, ".b_sel"}, 32'(op_b_sel), 32'(v.b));
      chk({tag, ".imm"}, imm, v.imm);
      chk({tag, ".reg_write"}, 32'(reg_write), 32'(v.we));
      chk({tag, ".illegal"}, 32'(illegal), 32'(v.ill));
      chk({tag, ".rs1"}, 32'(rs1_addr), 32'(v.instr[19:15]));
      chk({tag, ".rs2"}, 32'(rs2_addr), 32'(v.instr[24:20]));
      chk({tag, ".rd"}, 32'(rd_addr), 32'(v.instr[11:7]));
      chk({tag, ".pc_out"}, pc_out, p);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic ordy, input logic fl);
      in_valid = v; instr = ins; pc = p; out_ready = ordy; flush = fl;
   endtask

   // Instruction-level reference: legality and operands from the ISA rules.
   function automatic vec_t ref_decode(input logic [31:0] ins);
      vec_t        e;
      logic [3:0]  alu_by_f3 [8];
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        ok, writes;
      logic signed [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
      alu_by_f3 = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
      f3 = ins[14:12];
      f7 = ins[31:25];
      i_imm = {{20{ins[31]}}, ins[31:20]};
      s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      u_imm = {ins[31:12], 12'h000};
      j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      e.instr = ins; e.alu = 4'h0; e.a = 1'b0; e.b = 1'b0; e.imm = 32'h0; e.we = 1'b0; e.ill = 1'b0;
      ok = 1'b0;
      writes = 1'b0;
      case (ins[6:0])
         7'h33: begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            e.alu = alu_by_f3[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
            writes = 1'b1;
         end
         7'h13: begin
            e.b = 1'b1;
            writes = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
               e.imm = {27'b0, ins[24:20]};
               e.alu = alu_by_f3[f3] + ((f7 == 7'h20) ? 4'd1 : 4'd0);
            end else begin
               ok = 1'b1;
               e.imm = i_imm;
               e.alu = alu_by_f3[f3];
            end
         end
         7'h37: begin ok = 1'b1; e.alu = 4'hA; e.b = 1'b1; e.imm = u_imm; writes = 1'b1; end
         7'h17: begin ok = 1'b1; e.a = 1'b1; e.b = 1'b1; e.imm = u_imm; writes = 1'b1; end
         7'h03: begin ok = 1'b1; e.b = 1'b1; e.imm = i_imm; writes = 1'b1; end
         7'h23: begin ok = 1'b1; e.b = 1'b1; e.imm = s_imm; end
         7'h63: begin
            ok = (f3[2:1] != 2'b01);
            e.alu = (f3[2] == 1'b0) ? 4'h1 : (f3[1] ? 4'h4 : 4'h3);
            e.imm = b_imm;
         end
         7'h6F: begin ok = 1'b1; e.a = 1'b1; e.b = 1'b1; e.imm = j_imm; writes = 1'b1; end
         7'h67: begin ok = (f3 == 3'd0); e.b = 1'b1; e.imm = i_imm; writes = 1'b1; end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.alu = 4'h0; e.a = 1'b0; e.b = 1'b0; e.imm = 32'h0; e.ill = 1'b1; writes = 1'b0;
      end
      e.we = writes && (ins[11:7] != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] r;
      logic [6:0]  ops [9];
      ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
      r = $urandom;
      if ($urandom_range(0, 7) != 0) begin
         r[6:0] = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      return r;
   endfunction

   initial begin
      vec_t        m_b;
      logic        m_vld;
      logic [31:0] m_pc;

      //        instr         alu   a     b     imm            we    ill
      add_vec(32'h002081B3, 4'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0); // add x3,x1,x2
      add_vec(32'h407302B3, 4'h1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0); // sub
      add_vec(32'h40315093, 4'h7, 1'b0, 1'b1, 32'h3,        1'b1, 1'b0); // srai x1,x2,3
      add_vec(32'h02315093, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1); // bad f7
      add_vec(32'h12345237, 4'hA, 1'b0, 1'b1, 32'h12345000, 1'b1, 1'b0); // lui x4
      add_vec(32'hFFF00093, 4'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0); // addi x1,x0,-1
      add_vec(32'h00000013, 4'h0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0); // nop, rd=x0
      add_vec(32'h00001517, 4'h0, 1'b1, 1'b1, 32'h00001000, 1'b1, 1'b0); // auipc x10,1
      add_vec(32'h0020A423, 4'h0, 1'b0, 1'b1, 32'h8,        1'b0, 1'b0); // sw x2,8(x1)
      add_vec(32'hFF80A283, 4'h0, 1'b0, 1'b1, 32'hFFFFFFF8, 1'b1, 1'b0); // lw x5,-8(x1)
      add_vec(32'hFE208EE3, 4'h1, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0); // beq -4
      add_vec(32'hFE20DEE3, 4'h3, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0); // bge -4
      add_vec(32'hFE20EEE3, 4'h4, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0); // bltu -4
      add_vec(32'hFE20AEE3, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1); // branch f3=010
      add_vec(32'h008000EF, 4'h0, 1'b1, 1'b1, 32'h8,        1'b1, 1'b0); // jal x1,+8
      add_vec(32'hFFDFF06F, 4'h0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0); // j -4
      add_vec(32'h000280E7, 4'h0, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0); // jalr x1,0(x5)
      add_vec(32'h000290E7, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1); // jalr f3=001
      add_vec(32'h002081B0, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1); // instr[1:0]=00
      add_vec(32'h0000000B, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1); // custom opcode
      add_vec(32'h40209093, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1); // slli bad f7
      add_vec(32'h4020C1B3, 4'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1); // xor with f7=0x20
      add_vec(32'h0020D1B3, 4'h6, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0); // srl
      add_vec(32'h0020E1B3, 4'h8, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0); // or
      add_vec(32'h0020F1B3, 4'h9, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0); // and
      add_vec(32'h0020B1B3, 4'h4, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0); // sltu
      add_vec(32'h01F11093, 4'h2, 1'b0, 1'b1, 32'h1F,       1'b1, 1'b0); // slli 31
      add_vec(32'h41F15093, 4'h7, 1'b0, 1'b1, 32'h1F,       1'b1, 1'b0); // srai 31, no sign-ext
      add_vec(32'hFFF14093, 4'h5, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0); // xori -1

      // reset state
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst.out_valid", 32'(out_valid), 32'h0);
      chk("rst.in_ready", 32'(in_ready), 32'h1);
      chk("rst.pc_out", pc_out, RST_PC);
      chk("rst.alu", 32'(alu_control), 32'h0);
      chk("rst.imm", imm, 32'h0);
      chk("rst.reg_write", 32'(reg_write), 32'h0);
      chk("rst.illegal", 32'(illegal), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle.out_valid", 32'(out_valid), 32'h0);

      // decode table, back-to-back issue
      for (int i = 0; i < vecs.size(); i++) begin
         drive(1'b1, vecs[i].instr, 32'h100 + 32'(i) * 4, 1'b1, 1'b0);
         @(negedge clk);
         check_bundle($sformatf("vec%0d", i), vecs[i], 32'h100 + 32'(i) * 4);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("drain.out_valid", 32'(out_valid), 32'h0);

      // back-pressure: hold for three cycles, then accept with no bubble
      drive(1'b1, vecs[0].instr, 32'h200, 1'b1, 1'b0);
      @(negedge clk);
      check_bundle("bp.first", vecs[0], 32'h200);
      drive(1'b1, vecs[1].instr, 32'h204, 1'b0, 1'b0);
      #1 chk("bp.in_ready_low", 32'(in_ready), 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_bundle($sformatf("bp.hold%0d", k), vecs[0], 32'h200);
         chk($sformatf("bp.hold%0d.in_ready", k), 32'(in_ready), 32'h0);
      end
      out_ready = 1'b1;
      #1 chk("bp.in_ready_release", 32'(in_ready), 32'h1);
      @(negedge clk);
      check_bundle("bp.second", vecs[1], 32'h204);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("bp.empty", 32'(out_valid), 32'h0);

      // flush beats a same-cycle capture
      drive(1'b1, vecs[2].instr, 32'h300, 1'b1, 1'b0);
      @(negedge clk);
      check_bundle("fl.pre", vecs[2], 32'h300);
      drive(1'b1, vecs[4].instr, 32'h304, 1'b1, 1'b1);
      @(negedge clk);
      chk("fl.killed", 32'(out_valid), 32'h0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      chk("fl.not_presented", 32'(out_valid), 32'h0);
      // flush while stalled
      drive(1'b1, vecs[5].instr, 32'h308, 1'b0, 1'b0);
      @(negedge clk);
      check_bundle("fl.stall_pre", vecs[5], 32'h308);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      chk("fl.stall_killed", 32'(out_valid), 32'h0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // asynchronous reset mid-transfer
      drive(1'b1, vecs[4].instr, 32'h400, 1'b0, 1'b0);
      @(negedge clk);
      check_bundle("ar.pre", vecs[4], 32'h400);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.out_valid", 32'(out_valid), 32'h0);
      chk("ar.pc_out", pc_out, RST_PC);
      chk("ar.imm", imm, 32'h0);
      chk("ar.alu", 32'(alu_control), 32'h0);
      chk("ar.in_ready", 32'(in_ready), 32'h1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic against the reference model
      m_vld = 1'b0;
      m_pc  = 32'h0;
      m_b   = ref_decode(32'h0);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         chk("rnd.out_valid", 32'(out_valid), 32'(m_vld));
         if (m_vld) check_bundle("rnd", m_b, m_pc);
         drive(($urandom_range(0, 3) != 0), gen_instr(), $urandom & 32'hFFFF_FFFC,
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
         #1 chk("rnd.in_ready", 32'(in_ready), 32'(!m_vld || out_ready));
         if (flush) begin
            m_vld = 1'b0;
         end else if (in_valid && (!m_vld || out_ready)) begin
            m_vld = 1'b1;
            m_b   = ref_decode(instr);
            m_pc  = pc;
         end else if (out_ready) begin
            m_vld = 1'b0;
         end
         @(posedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
